seg7_result_display: RTL

- Consumer end of the Nexys 4 adder datapath. Latches operands A, B and result {cout,sum} on a load request, then shows them in hex on the board's 8-digit multiplexed 7-segment display.
- The load request comes from a raw push-button, which this block synchronises and edge-detects.
- Sits beside the ripple-carry adder in the board top and replaces LED-only result readout.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_result_display_hex.sv | 11 +
 rtl/seg7_result_display.sv | 105 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the adder result 7-segment display.
// Glyphs are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    typedef logic [2:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam digit_idx_t DIG_A_HI   = 3'd7;
    localparam digit_idx_t DIG_A_LO   = 3'd6;
    localparam digit_idx_t DIG_B_HI   = 3'd5;
    localparam digit_idx_t DIG_B_LO   = 3'd4;
    localparam digit_idx_t DIG_BLANK  = 3'd3;
    localparam digit_idx_t DIG_COUT   = 3'd2;
    localparam digit_idx_t DIG_SUM_HI = 3'd1;
    localparam digit_idx_t DIG_SUM_LO = 3'd0;

endpackage

// File: rtl/seg7_result_display_hex.sv
// Combinational hex nibble to active-low 7-segment glyph.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    assign glyph = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg7_result_display.sv
// Latches adder operands/result on a button press and scans them
// in hex across the 8-digit multiplexed 7-segment display.
module seg7_result_display
    import seg7_pkg::*;
#(
    parameter int N               = 8,
    parameter int TICKS_PER_DIGIT = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] sum,
    input  logic         cout,
    input  logic         btn_load,
    output logic [7:0]   an,
    output logic [6:0]   seg,
    output logic         dp,
    output logic         loaded
);

    localparam int TW = $clog2(TICKS_PER_DIGIT);

    if (N < 1 || N > 8) begin : g_bad_n
        $error("seg7_result_display: N must be 1..8");
    end

    logic [1:0]    sync_q;
    logic          edge_q;
    logic          load_pulse;
    logic [7:0]    snap_a;
    logic [7:0]    snap_b;
    logic [7:0]    snap_sum;
    logic          snap_cout;
    logic [TW-1:0] tick_cnt;
    logic          tick_wrap;
    digit_idx_t    d;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    glyph;

    assign load_pulse = sync_q[1] & ~edge_q;
    assign tick_wrap  = (tick_cnt == TW'(TICKS_PER_DIGIT - 1));

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        unique case (d)
            DIG_A_HI:   nibble = snap_a[7:4];
            DIG_A_LO:   nibble = snap_a[3:0];
            DIG_B_HI:   nibble = snap_b[7:4];
            DIG_B_LO:   nibble = snap_b[3:0];
            DIG_BLANK:  blank  = 1'b1;
            DIG_COUT:   nibble = {3'b000, snap_cout};
            DIG_SUM_HI: nibble = snap_sum[7:4];
            DIG_SUM_LO: nibble = snap_sum[3:0];
            default:    blank  = 1'b1;
        endcase
        // Nothing meaningful to show until the first snapshot
        if (!loaded) blank = 1'b1;
    end

    hex_to_7seg u_hex (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            edge_q    <= 1'b0;
            snap_a    <= 8'h00;
            snap_b    <= 8'h00;
            snap_sum  <= 8'h00;
            snap_cout <= 1'b0;
            loaded    <= 1'b0;
            tick_cnt  <= '0;
            d         <= '0;
            an        <= 8'hFF;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], btn_load};
            edge_q <= sync_q[1];
            if (load_pulse) begin
                snap_a    <= 8'(a);
                snap_b    <= 8'(b);
                snap_sum  <= 8'(sum);
                snap_cout <= cout;
                loaded    <= 1'b1;
            end
            if (tick_wrap) begin
                tick_cnt <= '0;
                d        <= d + 3'd1;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
            // an/seg/dp share one register stage so digits never ghost
            an  <= ~(8'b1 << d);
            seg <= blank ? SEG_BLANK : glyph;
            dp  <= ~(loaded && (d == DIG_B_LO || d == DIG_A_LO));
        end
    end

endmodule
